// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - 4-digit seven-segment scan controller with frame-synchronous shadow value
module digit_scan_ctrl #(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [1:0]  sel,
    output logic [3:0]  nibble,
    output logic        dp,
    output logic        blank,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             frame_done_q, frame_done_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [3:0]       shadow_dp_q, shadow_dp_d;
    logic [15:0]      pend_q, pend_d;
    logic [3:0]       pend_dp_q, pend_dp_d;
    logic             pend_valid_q, pend_valid_d;

    logic tick;
    logic boundary;

    assign tick     = en && (cnt_q == CNT_LAST);
    assign boundary = tick && (sel_q == 2'd3);

    always_comb begin
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        frame_done_d = boundary;
        shadow_d     = shadow_q;
        shadow_dp_d  = shadow_dp_q;
        pend_d       = pend_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;

        if (en) begin
            if (tick) begin
                cnt_d = '0;
                sel_d = sel_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A load landing on the boundary bypasses pending so it shows in the very next frame.
        if (boundary) begin
            if (load) begin
                shadow_d    = value;
                shadow_dp_d = dp_in;
            end else if (pend_valid_q) begin
                shadow_d    = pend_q;
                shadow_dp_d = pend_dp_q;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_d       = value;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            sel_q        <= 2'd0;
            frame_done_q <= 1'b0;
            shadow_q     <= 16'h0000;
            shadow_dp_q  <= 4'h0;
            pend_q       <= 16'h0000;
            pend_dp_q    <= 4'h0;
            pend_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
            shadow_q     <= shadow_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        case (sel_q)
            2'd0: begin
                nibble = shadow_q[3:0];
                blank  = 1'b0;
            end
            2'd1: begin
                nibble = shadow_q[7:4];
                blank  = blank_lz && (shadow_q[15:4] == 12'h000) && !shadow_dp_q[1];
            end
            2'd2: begin
                nibble = shadow_q[11:8];
                blank  = blank_lz && (shadow_q[15:8] == 8'h00) && !shadow_dp_q[2];
            end
            default: begin
                nibble = shadow_q[15:12];
                blank  = blank_lz && (shadow_q[15:12] == 4'h0) && !shadow_dp_q[3];
            end
        endcase
    end

    assign sel        = sel_q;
    assign dp         = shadow_dp_q[sel_q];
    assign frame_done = frame_done_q;

endmodule
